// File: rtl/axi_chan_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_typedef_pkg
// Description : Shared AXI4 type definitions for the channel buffer slice.
//               Fixed-width field typedefs (len_t, size_t, burst_t, ...),
//               default-width packed channel structs, and constant helper
//               functions that size channel payload vectors and occupancy
//               counters for arbitrary width/depth parameters.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package axi_typedef_pkg;

    // Default widths used by the packed channel structs below.
    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_DATA_WIDTH = 64;
    localparam int unsigned DEF_ID_WIDTH   = 4;
    localparam int unsigned DEF_USER_WIDTH = 1;

    typedef logic [7:0] len_t;
    typedef logic [2:0] size_t;
    typedef logic [1:0] burst_t;
    typedef logic [3:0] cache_t;
    typedef logic [2:0] prot_t;
    typedef logic [3:0] qos_t;
    typedef logic [3:0] region_t;
    typedef logic [5:0] atop_t;
    typedef logic [1:0] resp_t;

    typedef logic [DEF_ID_WIDTH-1:0]     id_t;
    typedef logic [DEF_ADDR_WIDTH-1:0]   addr_t;
    typedef logic [DEF_DATA_WIDTH-1:0]   data_t;
    typedef logic [DEF_DATA_WIDTH/8-1:0] strb_t;
    typedef logic [DEF_USER_WIDTH-1:0]   user_t;

    typedef struct packed {
        id_t     id;
        addr_t   addr;
        len_t    len;
        size_t   size;
        burst_t  burst;
        logic    lock;
        cache_t  cache;
        prot_t   prot;
        qos_t    qos;
        region_t region;
        atop_t   atop;
        user_t   user;
    } aw_chan_t;

    typedef struct packed {
        data_t data;
        strb_t strb;
        logic  last;
        user_t user;
    } w_chan_t;

    typedef struct packed {
        id_t   id;
        resp_t resp;
        user_t user;
    } b_chan_t;

    typedef struct packed {
        id_t     id;
        addr_t   addr;
        len_t    len;
        size_t   size;
        burst_t  burst;
        logic    lock;
        cache_t  cache;
        prot_t   prot;
        qos_t    qos;
        region_t region;
        user_t   user;
    } ar_chan_t;

    typedef struct packed {
        id_t   id;
        data_t data;
        resp_t resp;
        logic  last;
        user_t user;
    } r_chan_t;

    // Address-channel fields whose width never depends on parameters.
    localparam int unsigned AX_FIXED_WIDTH = $bits(len_t) + $bits(size_t) + $bits(burst_t) + 1
                                           + $bits(cache_t) + $bits(prot_t) + $bits(qos_t)
                                           + $bits(region_t);

    // Occupancy counter width; a zero-depth channel still gets a 1-bit port.
    function automatic int unsigned occ_width(input int unsigned depth);
        return (depth == 0) ? 1 : $clog2(depth + 1);
    endfunction

    function automatic int unsigned aw_payload_width(input int unsigned idw, input int unsigned aw,
                                                     input int unsigned uw);
        return idw + aw + AX_FIXED_WIDTH + $bits(atop_t) + uw;
    endfunction

    function automatic int unsigned ar_payload_width(input int unsigned idw, input int unsigned aw,
                                                     input int unsigned uw);
        return idw + aw + AX_FIXED_WIDTH + uw;
    endfunction

    function automatic int unsigned w_payload_width(input int unsigned dw, input int unsigned uw);
        return dw + dw / 8 + 1 + uw;
    endfunction

    function automatic int unsigned b_payload_width(input int unsigned idw, input int unsigned uw);
        return idw + $bits(resp_t) + uw;
    endfunction

    function automatic int unsigned r_payload_width(input int unsigned idw, input int unsigned dw,
                                                    input int unsigned uw);
        return idw + dw + $bits(resp_t) + 1 + uw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_chan_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_inf_for_design
// Description : Full AXI4 five-channel bundle (AW, W, B, AR, R incl. atop
//               and user) with Master/Slave modports.
// Ports       : none; signals accessed through modports
//               Master - drives AW/W/AR payload+valid, B/R ready
//               Slave  - drives AW/W/AR ready, B/R payload+valid
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_inf_for_design #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 1
);
    import axi_typedef_pkg::*;

    logic [AXI_ID_WIDTH-1:0]     aw_id;
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
    len_t                        aw_len;
    size_t                       aw_size;
    burst_t                      aw_burst;
    logic                        aw_lock;
    cache_t                      aw_cache;
    prot_t                       aw_prot;
    qos_t                        aw_qos;
    region_t                     aw_region;
    atop_t                       aw_atop;
    logic [AXI_USER_WIDTH-1:0]   aw_user;
    logic                        aw_valid;
    logic                        aw_ready;

    logic [AXI_DATA_WIDTH-1:0]   w_data;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb;
    logic                        w_last;
    logic [AXI_USER_WIDTH-1:0]   w_user;
    logic                        w_valid;
    logic                        w_ready;

    logic [AXI_ID_WIDTH-1:0]     b_id;
    resp_t                       b_resp;
    logic [AXI_USER_WIDTH-1:0]   b_user;
    logic                        b_valid;
    logic                        b_ready;

    logic [AXI_ID_WIDTH-1:0]     ar_id;
    logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
    len_t                        ar_len;
    size_t                       ar_size;
    burst_t                      ar_burst;
    logic                        ar_lock;
    cache_t                      ar_cache;
    prot_t                       ar_prot;
    qos_t                        ar_qos;
    region_t                     ar_region;
    logic [AXI_USER_WIDTH-1:0]   ar_user;
    logic                        ar_valid;
    logic                        ar_ready;

    logic [AXI_ID_WIDTH-1:0]     r_id;
    logic [AXI_DATA_WIDTH-1:0]   r_data;
    resp_t                       r_resp;
    logic                        r_last;
    logic [AXI_USER_WIDTH-1:0]   r_user;
    logic                        r_valid;
    logic                        r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );

endinterface
`default_nettype wire

// File: rtl/axi_chan_buffer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : axi_chan_fifo
// Description : Single-channel registered valid/ready FIFO (DEPTH >= 1).
//               Push ready depends only on the fill count, pop valid and
//               payload come from registers, so every path is cut.
//               Any DEPTH works (pointers wrap explicitly).
// Ports       : clk, rst_n (async, active low)
//               in_valid/in_ready/in_data    - push side
//               out_valid/out_ready/out_data - pop side
//               count                        - current fill level
// Revision    : 1.0 - initial release
// ============================================================================
module axi_chan_fifo
    import axi_typedef_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 2
) (
    input  wire logic                         clk,
    input  wire logic                         rst_n,
    input  wire logic                         in_valid,
    output logic                              in_ready,
    input  wire logic [DATA_WIDTH-1:0]        in_data,
    output logic                              out_valid,
    input  wire logic                         out_ready,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic [occ_width(DEPTH)-1:0]       count
);

    localparam int unsigned          c_ptr_w    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned          c_cnt_w    = occ_width(DEPTH);
    localparam logic [c_ptr_w-1:0]   c_last_ptr = c_ptr_w'(DEPTH - 1);
    localparam logic [c_cnt_w-1:0]   c_full     = c_cnt_w'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_ptr_w-1:0]    r_wptr;
    logic [c_ptr_w-1:0]    r_rptr;
    logic [c_cnt_w-1:0]    r_count;
    logic                  w_push;
    logic                  w_pop;

    // Full blocks the push even while a pop is in flight: keeps in_ready free
    // of any out_ready dependency.
    assign in_ready  = (r_count != c_full);
    assign out_valid = (r_count != '0);
    assign out_data  = r_mem[r_rptr];
    assign count     = r_count;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    function automatic logic [c_ptr_w-1:0] next_ptr(input logic [c_ptr_w-1:0] ptr);
        return (ptr == c_last_ptr) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= next_ptr(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= next_ptr(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; contents are meaningless while out_valid = 0.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_chan_buffer.sv
`default_nettype none
// ============================================================================
// Module      : axi_chan_buffer
// Description : Five-channel AXI4 buffer. Each channel is either a plain
//               wire-through (DEPTH = 0) or an axi_chan_fifo (DEPTH >= 1).
//               Forward channels (AW, W, AR) push from slv and pop to mst;
//               reverse channels (B, R) push from mst and pop to slv.
//               Optional macro AXI_CHAN_BUFFER_OCC_EN adds occ_* fill ports.
// Ports       : clk, rst_n (async, active low)
//               slv - upstream side (Slave modport)
//               mst - downstream side (Master modport)
//               occ_aw/occ_w/occ_b/occ_ar/occ_r - fill levels (macro only)
// Revision    : 1.0 - initial release
// ============================================================================
module axi_chan_buffer
    import axi_typedef_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 1,
    parameter int unsigned AW_DEPTH       = 2,
    parameter int unsigned W_DEPTH        = 4,
    parameter int unsigned B_DEPTH        = 2,
    parameter int unsigned AR_DEPTH       = 2,
    parameter int unsigned R_DEPTH        = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    axi_inf_for_design.Slave  slv,
    axi_inf_for_design.Master mst
`ifdef AXI_CHAN_BUFFER_OCC_EN
    ,
    output logic [occ_width(AW_DEPTH)-1:0] occ_aw,
    output logic [occ_width(W_DEPTH)-1:0]  occ_w,
    output logic [occ_width(B_DEPTH)-1:0]  occ_b,
    output logic [occ_width(AR_DEPTH)-1:0] occ_ar,
    output logic [occ_width(R_DEPTH)-1:0]  occ_r
`endif
);

    localparam int unsigned c_aw_w = aw_payload_width(AXI_ID_WIDTH, AXI_ADDR_WIDTH, AXI_USER_WIDTH);
    localparam int unsigned c_w_w  = w_payload_width(AXI_DATA_WIDTH, AXI_USER_WIDTH);
    localparam int unsigned c_b_w  = b_payload_width(AXI_ID_WIDTH, AXI_USER_WIDTH);
    localparam int unsigned c_ar_w = ar_payload_width(AXI_ID_WIDTH, AXI_ADDR_WIDTH, AXI_USER_WIDTH);
    localparam int unsigned c_r_w  = r_payload_width(AXI_ID_WIDTH, AXI_DATA_WIDTH, AXI_USER_WIDTH);

    logic [c_aw_w-1:0] w_aw_in, w_aw_out;
    logic [c_w_w-1:0]  w_w_in,  w_w_out;
    logic [c_b_w-1:0]  w_b_in,  w_b_out;
    logic [c_ar_w-1:0] w_ar_in, w_ar_out;
    logic [c_r_w-1:0]  w_r_in,  w_r_out;

    logic [occ_width(AW_DEPTH)-1:0] w_aw_cnt;
    logic [occ_width(W_DEPTH)-1:0]  w_w_cnt;
    logic [occ_width(B_DEPTH)-1:0]  w_b_cnt;
    logic [occ_width(AR_DEPTH)-1:0] w_ar_cnt;
    logic [occ_width(R_DEPTH)-1:0]  w_r_cnt;

    // Payload packing: every non-handshake field of the channel.
    assign w_aw_in = {slv.aw_id, slv.aw_addr, slv.aw_len, slv.aw_size, slv.aw_burst, slv.aw_lock,
                      slv.aw_cache, slv.aw_prot, slv.aw_qos, slv.aw_region, slv.aw_atop, slv.aw_user};
    assign {mst.aw_id, mst.aw_addr, mst.aw_len, mst.aw_size, mst.aw_burst, mst.aw_lock,
            mst.aw_cache, mst.aw_prot, mst.aw_qos, mst.aw_region, mst.aw_atop, mst.aw_user} = w_aw_out;

    assign w_w_in = {slv.w_data, slv.w_strb, slv.w_last, slv.w_user};
    assign {mst.w_data, mst.w_strb, mst.w_last, mst.w_user} = w_w_out;

    assign w_b_in = {mst.b_id, mst.b_resp, mst.b_user};
    assign {slv.b_id, slv.b_resp, slv.b_user} = w_b_out;

    assign w_ar_in = {slv.ar_id, slv.ar_addr, slv.ar_len, slv.ar_size, slv.ar_burst, slv.ar_lock,
                      slv.ar_cache, slv.ar_prot, slv.ar_qos, slv.ar_region, slv.ar_user};
    assign {mst.ar_id, mst.ar_addr, mst.ar_len, mst.ar_size, mst.ar_burst, mst.ar_lock,
            mst.ar_cache, mst.ar_prot, mst.ar_qos, mst.ar_region, mst.ar_user} = w_ar_out;

    assign w_r_in = {mst.r_id, mst.r_data, mst.r_resp, mst.r_last, mst.r_user};
    assign {slv.r_id, slv.r_data, slv.r_resp, slv.r_last, slv.r_user} = w_r_out;

    generate
        if (AW_DEPTH == 0) begin : g_aw_pass
            assign mst.aw_valid = slv.aw_valid;
            assign slv.aw_ready = mst.aw_ready;
            assign w_aw_out     = w_aw_in;
            assign w_aw_cnt     = '0;
        end else begin : g_aw_fifo
            axi_chan_fifo #(.DATA_WIDTH(c_aw_w), .DEPTH(AW_DEPTH)) u_fifo (
                .clk(clk), .rst_n(rst_n),
                .in_valid(slv.aw_valid), .in_ready(slv.aw_ready), .in_data(w_aw_in),
                .out_valid(mst.aw_valid), .out_ready(mst.aw_ready), .out_data(w_aw_out),
                .count(w_aw_cnt)
            );
        end

        if (W_DEPTH == 0) begin : g_w_pass
            assign mst.w_valid = slv.w_valid;
            assign slv.w_ready = mst.w_ready;
            assign w_w_out     = w_w_in;
            assign w_w_cnt     = '0;
        end else begin : g_w_fifo
            axi_chan_fifo #(.DATA_WIDTH(c_w_w), .DEPTH(W_DEPTH)) u_fifo (
                .clk(clk), .rst_n(rst_n),
                .in_valid(slv.w_valid), .in_ready(slv.w_ready), .in_data(w_w_in),
                .out_valid(mst.w_valid), .out_ready(mst.w_ready), .out_data(w_w_out),
                .count(w_w_cnt)
            );
        end

        if (B_DEPTH == 0) begin : g_b_pass
            assign slv.b_valid = mst.b_valid;
            assign mst.b_ready = slv.b_ready;
            assign w_b_out     = w_b_in;
            assign w_b_cnt     = '0;
        end else begin : g_b_fifo
            axi_chan_fifo #(.DATA_WIDTH(c_b_w), .DEPTH(B_DEPTH)) u_fifo (
                .clk(clk), .rst_n(rst_n),
                .in_valid(mst.b_valid), .in_ready(mst.b_ready), .in_data(w_b_in),
                .out_valid(slv.b_valid), .out_ready(slv.b_ready), .out_data(w_b_out),
                .count(w_b_cnt)
            );
        end

        if (AR_DEPTH == 0) begin : g_ar_pass
            assign mst.ar_valid = slv.ar_valid;
            assign slv.ar_ready = mst.ar_ready;
            assign w_ar_out     = w_ar_in;
            assign w_ar_cnt     = '0;
        end else begin : g_ar_fifo
            axi_chan_fifo #(.DATA_WIDTH(c_ar_w), .DEPTH(AR_DEPTH)) u_fifo (
                .clk(clk), .rst_n(rst_n),
                .in_valid(slv.ar_valid), .in_ready(slv.ar_ready), .in_data(w_ar_in),
                .out_valid(mst.ar_valid), .out_ready(mst.ar_ready), .out_data(w_ar_out),
                .count(w_ar_cnt)
            );
        end

        if (R_DEPTH == 0) begin : g_r_pass
            assign slv.r_valid = mst.r_valid;
            assign mst.r_ready = slv.r_ready;
            assign w_r_out     = w_r_in;
            assign w_r_cnt     = '0;
        end else begin : g_r_fifo
            axi_chan_fifo #(.DATA_WIDTH(c_r_w), .DEPTH(R_DEPTH)) u_fifo (
                .clk(clk), .rst_n(rst_n),
                .in_valid(mst.r_valid), .in_ready(mst.r_ready), .in_data(w_r_in),
                .out_valid(slv.r_valid), .out_ready(slv.r_ready), .out_data(w_r_out),
                .count(w_r_cnt)
            );
        end
    endgenerate

`ifdef AXI_CHAN_BUFFER_OCC_EN
    assign occ_aw = w_aw_cnt;
    assign occ_w  = w_w_cnt;
    assign occ_b  = w_b_cnt;
    assign occ_ar = w_ar_cnt;
    assign occ_r  = w_r_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_chan_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_chan_buffer
// Description : Self-checking bench for axi_chan_buffer (AW depth 1, W 4,
//               B 2, AR 2, R 3). Per-channel queues model each buffer as an
//               in-order store with capacity DEPTH; a negedge monitor compares
//               DUT ready/valid/payload against the queues.
//               Occupancy checks are compiled in with AXI_CHAN_BUFFER_OCC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_chan_buffer;
    import axi_typedef_pkg::*;

    localparam int AW_D = 1;
    localparam int W_D  = 4;
    localparam int B_D  = 2;
    localparam int AR_D = 2;
    localparam int R_D  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_inf_for_design #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4),
                         .AXI_USER_WIDTH(1)) slv_if ();
    axi_inf_for_design #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4),
                         .AXI_USER_WIDTH(1)) mst_if ();

`ifdef AXI_CHAN_BUFFER_OCC_EN
    logic [occ_width(AW_D)-1:0] occ_aw;
    logic [occ_width(W_D)-1:0]  occ_w;
    logic [occ_width(B_D)-1:0]  occ_b;
    logic [occ_width(AR_D)-1:0] occ_ar;
    logic [occ_width(R_D)-1:0]  occ_r;
`endif

    axi_chan_buffer #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(1),
        .AW_DEPTH(AW_D), .W_DEPTH(W_D), .B_DEPTH(B_D), .AR_DEPTH(AR_D), .R_DEPTH(R_D)
    ) dut (
        .clk(clk), .rst_n(rst_n), .slv(slv_if), .mst(mst_if)
`ifdef AXI_CHAN_BUFFER_OCC_EN
        , .occ_aw(occ_aw), .occ_w(occ_w), .occ_b(occ_b), .occ_ar(occ_ar), .occ_r(occ_r)
`endif
    );

    // Channel payload views on both sides of the buffer.
    logic [127:0] aw_in, aw_out, w_in, w_out, b_in, b_out, ar_in, ar_out, r_in, r_out;
    assign aw_in  = 128'({slv_if.aw_id, slv_if.aw_addr, slv_if.aw_len, slv_if.aw_size, slv_if.aw_burst,
                          slv_if.aw_lock, slv_if.aw_cache, slv_if.aw_prot, slv_if.aw_qos,
                          slv_if.aw_region, slv_if.aw_atop, slv_if.aw_user});
    assign aw_out = 128'({mst_if.aw_id, mst_if.aw_addr, mst_if.aw_len, mst_if.aw_size, mst_if.aw_burst,
                          mst_if.aw_lock, mst_if.aw_cache, mst_if.aw_prot, mst_if.aw_qos,
                          mst_if.aw_region, mst_if.aw_atop, mst_if.aw_user});
    assign w_in   = 128'({slv_if.w_data, slv_if.w_strb, slv_if.w_last, slv_if.w_user});
    assign w_out  = 128'({mst_if.w_data, mst_if.w_strb, mst_if.w_last, mst_if.w_user});
    assign b_in   = 128'({mst_if.b_id, mst_if.b_resp, mst_if.b_user});
    assign b_out  = 128'({slv_if.b_id, slv_if.b_resp, slv_if.b_user});
    assign ar_in  = 128'({slv_if.ar_id, slv_if.ar_addr, slv_if.ar_len, slv_if.ar_size, slv_if.ar_burst,
                          slv_if.ar_lock, slv_if.ar_cache, slv_if.ar_prot, slv_if.ar_qos,
                          slv_if.ar_region, slv_if.ar_user});
    assign ar_out = 128'({mst_if.ar_id, mst_if.ar_addr, mst_if.ar_len, mst_if.ar_size, mst_if.ar_burst,
                          mst_if.ar_lock, mst_if.ar_cache, mst_if.ar_prot, mst_if.ar_qos,
                          mst_if.ar_region, mst_if.ar_user});
    assign r_in   = 128'({mst_if.r_id, mst_if.r_data, mst_if.r_resp, mst_if.r_last, mst_if.r_user});
    assign r_out  = 128'({slv_if.r_id, slv_if.r_data, slv_if.r_resp, slv_if.r_last, slv_if.r_user});

    int total = 0;
    int bad   = 0;

    logic [127:0] q_aw[$], q_w[$], q_b[$], q_ar[$], q_r[$];
    bit hs_aw_push, hs_aw_pop, hs_w_push, hs_w_pop, hs_b_push, hs_b_pop;
    bit hs_ar_push, hs_ar_pop, hs_r_push, hs_r_pop;
    int n_aw_push = 0, n_aw_pop = 0, n_w_push = 0, n_w_pop = 0, n_b_push = 0, n_b_pop = 0;
    int n_ar_push = 0, n_ar_pop = 0, n_r_push = 0, n_r_pop = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One channel of the scoreboard: ready/valid must reflect the model's
    // fill level, the head entry must be presented whenever valid, and
    // handshakes move entries through the model queue.
    task automatic mon_chan(input string nm, input int depth, inout logic [127:0] q[$],
                            input logic push_v, input logic push_r, input logic [127:0] push_d,
                            input logic pop_v, input logic pop_r, input logic [127:0] pop_d,
                            output bit hs_push, output bit hs_pop,
                            inout int n_push, inout int n_pop);
        chk({nm, "_push_ready"}, push_r, q.size() != depth);
        chk({nm, "_pop_valid"}, pop_v, q.size() != 0);
        if (pop_v && q.size() != 0) chk({nm, "_payload"}, pop_d, q[0]);
        hs_push = push_v && push_r;
        hs_pop  = pop_v && pop_r;
        if (hs_pop) begin
            if (q.size() != 0) void'(q.pop_front());
            n_pop++;
        end
        if (hs_push) begin
            q.push_back(push_d);
            n_push++;
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            q_aw.delete(); q_w.delete(); q_b.delete(); q_ar.delete(); q_r.delete();
            {hs_aw_push, hs_aw_pop, hs_w_push, hs_w_pop, hs_b_push, hs_b_pop} = '0;
            {hs_ar_push, hs_ar_pop, hs_r_push, hs_r_pop} = '0;
        end else begin
            mon_chan("aw", AW_D, q_aw, slv_if.aw_valid, slv_if.aw_ready, aw_in,
                     mst_if.aw_valid, mst_if.aw_ready, aw_out, hs_aw_push, hs_aw_pop, n_aw_push, n_aw_pop);
            mon_chan("w", W_D, q_w, slv_if.w_valid, slv_if.w_ready, w_in,
                     mst_if.w_valid, mst_if.w_ready, w_out, hs_w_push, hs_w_pop, n_w_push, n_w_pop);
            mon_chan("b", B_D, q_b, mst_if.b_valid, mst_if.b_ready, b_in,
                     slv_if.b_valid, slv_if.b_ready, b_out, hs_b_push, hs_b_pop, n_b_push, n_b_pop);
            mon_chan("ar", AR_D, q_ar, slv_if.ar_valid, slv_if.ar_ready, ar_in,
                     mst_if.ar_valid, mst_if.ar_ready, ar_out, hs_ar_push, hs_ar_pop, n_ar_push, n_ar_pop);
            mon_chan("r", R_D, q_r, mst_if.r_valid, mst_if.r_ready, r_in,
                     slv_if.r_valid, slv_if.r_ready, r_out, hs_r_push, hs_r_pop, n_r_push, n_r_pop);
        end
    end

    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_aw();
        slv_if.aw_id = 4'($urandom); slv_if.aw_addr = $urandom; slv_if.aw_len = 8'($urandom);
        slv_if.aw_size = 3'($urandom); slv_if.aw_burst = 2'($urandom); slv_if.aw_lock = 1'($urandom);
        slv_if.aw_cache = 4'($urandom); slv_if.aw_prot = 3'($urandom); slv_if.aw_qos = 4'($urandom);
        slv_if.aw_region = 4'($urandom); slv_if.aw_atop = 6'($urandom); slv_if.aw_user = 1'($urandom);
    endtask

    task automatic rand_w();
        slv_if.w_data = {$urandom, $urandom}; slv_if.w_strb = 8'($urandom);
        slv_if.w_last = 1'($urandom); slv_if.w_user = 1'($urandom);
    endtask

    task automatic rand_b();
        mst_if.b_id = 4'($urandom); mst_if.b_resp = 2'($urandom); mst_if.b_user = 1'($urandom);
    endtask

    task automatic rand_ar();
        slv_if.ar_id = 4'($urandom); slv_if.ar_addr = $urandom; slv_if.ar_len = 8'($urandom);
        slv_if.ar_size = 3'($urandom); slv_if.ar_burst = 2'($urandom); slv_if.ar_lock = 1'($urandom);
        slv_if.ar_cache = 4'($urandom); slv_if.ar_prot = 3'($urandom); slv_if.ar_qos = 4'($urandom);
        slv_if.ar_region = 4'($urandom); slv_if.ar_user = 1'($urandom);
    endtask

    task automatic rand_r();
        mst_if.r_id = 4'($urandom); mst_if.r_data = {$urandom, $urandom}; mst_if.r_resp = 2'($urandom);
        mst_if.r_last = 1'($urandom); mst_if.r_user = 1'($urandom);
    endtask

    function automatic logic coin(input int pct);
        return ($urandom_range(0, 99) < pct);
    endfunction

    // Valid is only re-chosen once the current beat was taken (AXI hold rule).
    task automatic drive_random(input int pv, input int pr);
        if (!slv_if.aw_valid || hs_aw_push) begin slv_if.aw_valid = coin(pv); rand_aw(); end
        if (!slv_if.w_valid  || hs_w_push)  begin slv_if.w_valid  = coin(pv); rand_w();  end
        if (!mst_if.b_valid  || hs_b_push)  begin mst_if.b_valid  = coin(pv); rand_b();  end
        if (!slv_if.ar_valid || hs_ar_push) begin slv_if.ar_valid = coin(pv); rand_ar(); end
        if (!mst_if.r_valid  || hs_r_push)  begin mst_if.r_valid  = coin(pv); rand_r();  end
        mst_if.aw_ready = coin(pr); mst_if.w_ready = coin(pr); slv_if.b_ready = coin(pr);
        mst_if.ar_ready = coin(pr); slv_if.r_ready = coin(pr);
    endtask

    task automatic idle_all(input logic rdy);
        slv_if.aw_valid = 0; slv_if.w_valid = 0; mst_if.b_valid = 0; slv_if.ar_valid = 0;
        mst_if.r_valid = 0;
        mst_if.aw_ready = rdy; mst_if.w_ready = rdy; slv_if.b_ready = rdy;
        mst_if.ar_ready = rdy; slv_if.r_ready = rdy;
    endtask

    initial begin : main
        int base_push, base_pop, cyc;
        rand_aw(); rand_w(); rand_b(); rand_ar(); rand_r();
        idle_all(1'b0);
        rst_n = 1'b0;
        repeat (3) wait_cycle();
        rst_n = 1'b1;
        wait_cycle();

        // Reset state with every downstream ready held low.
        chk("rst_mst_aw_valid", mst_if.aw_valid, 1'b0);
        chk("rst_slv_b_valid", slv_if.b_valid, 1'b0);
        chk("rst_slv_aw_ready", slv_if.aw_ready, 1'b1);
        chk("rst_slv_w_ready", slv_if.w_ready, 1'b1);
        chk("rst_slv_ar_ready", slv_if.ar_ready, 1'b1);
        chk("rst_mst_b_ready", mst_if.b_ready, 1'b1);
        chk("rst_mst_r_ready", mst_if.r_ready, 1'b1);

        // W fill: five beats 0x11..0x55 against a stalled downstream.
        base_push = n_w_push;
        slv_if.w_strb = '1; slv_if.w_user = 1'b0;
        for (int i = 0; i < 4; i++) begin
            slv_if.w_valid = 1'b1;
            slv_if.w_data  = 64'(8'h11 * (i + 1));
            slv_if.w_last  = 1'b0;
            wait_cycle();
            chk("w_fill_accept", hs_w_push, 1'b1);
        end
        slv_if.w_data = 64'h55; slv_if.w_last = 1'b1;
        repeat (3) wait_cycle();
        chk("w_fill_count", n_w_push - base_push, 4);
        chk("w_full_ready", slv_if.w_ready, 1'b0);
`ifdef AXI_CHAN_BUFFER_OCC_EN
        chk("occ_w_full", occ_w, 4);
`endif
        mst_if.w_ready = 1'b1;
        cyc = 0;
        while (!hs_w_push && cyc < 20) begin wait_cycle(); cyc++; end
        chk("w_fifth_accept", hs_w_push, 1'b1);
        slv_if.w_valid = 1'b0;
        repeat (8) wait_cycle();
        chk("w_drain_empty", q_w.size(), 0);

        // AR: 16 cycles of continuous valid with downstream always ready.
        mst_if.ar_ready = 1'b1;
        base_push = n_ar_push; base_pop = n_ar_pop;
        for (int i = 0; i < 16; i++) begin
            rand_ar();
            slv_if.ar_addr = 32'h1000 + 32'(i * 4);
            slv_if.ar_valid = 1'b1;
            wait_cycle();
        end
        slv_if.ar_valid = 1'b0;
        chk("ar_slv_hs", n_ar_push - base_push, 16);
        chk("ar_mst_hs", n_ar_pop - base_pop, 15);
        wait_cycle();

        // AW depth 1: half-rate acceptance.
        mst_if.aw_ready = 1'b1;
        base_push = n_aw_push; base_pop = n_aw_pop;
        rand_aw();
        slv_if.aw_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wait_cycle();
            if (hs_aw_push) rand_aw();
        end
        slv_if.aw_valid = 1'b0;
        chk("aw_d1_push", n_aw_push - base_push, 8);
        chk("aw_d1_pop", n_aw_pop - base_pop, 8);
        wait_cycle();

        // R depth 3 with random stalls on both sides, 10 beats.
        base_push = n_r_push; base_pop = n_r_pop;
        cyc = 0;
        while ((n_r_pop - base_pop < 10) && cyc < 400) begin
            if (n_r_push - base_push < 10) begin
                if (!mst_if.r_valid || hs_r_push) begin mst_if.r_valid = coin(60); rand_r(); end
            end else begin
                mst_if.r_valid = 1'b0;
            end
            slv_if.r_ready = coin(50);
            wait_cycle();
            cyc++;
            if (n_r_push - base_push >= 10 && hs_r_push) mst_if.r_valid = 1'b0;
        end
        mst_if.r_valid = 1'b0;
        slv_if.r_ready = 1'b1;
        chk("r_beats_in", n_r_push - base_push, 10);
        chk("r_beats_out", n_r_pop - base_pop, 10);
        wait_cycle();

        // B: hold two responses, then reset mid-flight.
        slv_if.b_ready = 1'b0;
        base_push = n_b_push;
        rand_b(); mst_if.b_valid = 1'b1;
        wait_cycle();
        rand_b();
        wait_cycle();
        mst_if.b_valid = 1'b0;
        chk("b_two_held", n_b_push - base_push, 2);
        chk("b_full_ready", mst_if.b_ready, 1'b0);
        chk("b_valid_before_rst", slv_if.b_valid, 1'b1);
`ifdef AXI_CHAN_BUFFER_OCC_EN
        chk("occ_b_two", occ_b, 2);
`endif
        rst_n = 1'b0;
        #1;
        chk("b_valid_async_rst", slv_if.b_valid, 1'b0);
`ifdef AXI_CHAN_BUFFER_OCC_EN
        chk("occ_b_rst", occ_b, 0);
`endif
        repeat (2) wait_cycle();
        rst_n = 1'b1;
        slv_if.b_ready = 1'b1;
        base_pop = n_b_pop;
        repeat (4) wait_cycle();
        chk("b_no_stale", n_b_pop - base_pop, 0);
        chk("b_ready_after_rst", mst_if.b_ready, 1'b1);

        // Random traffic on all channels, then drain.
        for (int i = 0; i < 400; i++) begin
            drive_random(60, 60);
            wait_cycle();
        end
        idle_all(1'b1);
        repeat (10) wait_cycle();
        chk("drain_aw", q_aw.size(), 0);
        chk("drain_w", q_w.size(), 0);
        chk("drain_b", q_b.size(), 0);
        chk("drain_ar", q_ar.size(), 0);
        chk("drain_r", q_r.size(), 0);
        chk("drain_r_count", n_r_push, n_r_pop);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
